// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Mode-vector bit positions and saturation constants live here.
package rca_pkg;

    localparam int MODE_SUB   = 0;
    localparam int MODE_SIGND = 1;
    localparam int MODE_W     = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [63:0] sat_smax(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_smin(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] sat_umax(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational ripple-carry slice of width W.
// Also exposes the carry into its top bit for signed overflow.
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    // Bitwise ripple carry chain across the slice
    always_comb begin
        logic [W:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int j = 0; j < W; j++) begin
            s[j]   = a[j] ^ b[j] ^ c[j];
            c[j+1] = (a[j] & b[j]) |
                     (a[j] & c[j]) |
                     (b[j] & c[j]);
        end
        cout     = c[W];
        c_msb_in = c[W-1];
    end

endmodule

// File: rtl/pipelined_addsub_hs.sv
// Pipelined ripple-carry add/sub with valid/ready on both sides.
// Optional macro SAT_EN saturates the result on overflow.
module pipelined_addsub_hs
    import rca_pkg::*;
#(
    parameter int Nbits   = 16,
    parameter int Nstages = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Nbits-1:0] a,
    input  logic [Nbits-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             signd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Nbits-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S = Nbits / Nstages;
    localparam int L = Nstages - 1;

    typedef logic [Nbits-1:0]  word_t;
    typedef logic [MODE_W-1:0] mode_t;

    if ((Nstages < 1) ||
        ((1 << clog2(Nstages)) != Nstages) ||
        ((Nbits % Nstages) != 0)) begin : g_chk
        $fatal(1, "pipelined_addsub_hs: bad Nbits/Nstages");
    end

`ifdef SAT_EN
    localparam word_t SMAX = word_t'(sat_smax(Nbits));
    localparam word_t SMIN = word_t'(sat_smin(Nbits));
    localparam word_t UMAX = word_t'(sat_umax(Nbits));
`endif

    logic [Nstages-1:0]             v_q;
    logic [Nstages-1:0][Nbits-1:0]  a_q;
    logic [Nstages-1:0][Nbits-1:0]  b_q;
    logic [Nstages-1:0][Nbits-1:0]  s_q;
    logic [Nstages-1:0]             c_q;
    logic [Nstages-1:0][MODE_W-1:0] m_q;
    logic                           ovf_q;

    logic [Nstages-1:0]             rdy;

    logic [Nstages-1:0]             src_v;
    logic [Nstages-1:0][Nbits-1:0]  src_a;
    logic [Nstages-1:0][Nbits-1:0]  src_b;
    logic [Nstages-1:0][Nbits-1:0]  src_s;
    logic [Nstages-1:0]             src_c;
    logic [Nstages-1:0][MODE_W-1:0] src_m;
    logic [Nstages-1:0][Nbits-1:0]  nxt_s;

    logic [Nstages-1:0][S-1:0]      sl_s;
    logic [Nstages-1:0]             sl_co;
    logic [Nstages-1:0]             sl_cm;

    word_t fin_sum;
    logic  fin_ovf;
    mode_t fin_m;

    // Ready chain: a stage accepts if empty or its successor accepts
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int i = Nstages - 1; i >= 0; i--) begin
            r      = !v_q[i] || r;
            rdy[i] = r;
        end
    end

    assign in_ready = rdy[0];

    // Operand/carry/mode sources feeding each stage
    always_comb begin
        mode_t m0;
        m0             = '0;
        m0[MODE_SUB]   = sub;
        m0[MODE_SIGND] = signd;
        src_v    = '0;
        src_a    = '0;
        src_b    = '0;
        src_s    = '0;
        src_c    = '0;
        src_m    = '0;
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub ? ~cin : cin;
        src_m[0] = m0;
        for (int i = 1; i < Nstages; i++) begin
            src_v[i] = v_q[i-1];
            src_a[i] = a_q[i-1];
            src_b[i] = b_q[i-1];
            src_s[i] = s_q[i-1];
            src_c[i] = c_q[i-1];
            src_m[i] = m_q[i-1];
        end
    end

    for (genvar g = 0; g < Nstages; g++) begin : g_slice
        addsub_slice #(
            .W(S)
        ) u_slice (
            .a        (src_a[g][g*S +: S]),
            .b        (src_b[g][g*S +: S]),
            .cin      (src_c[g]),
            .s        (sl_s[g]),
            .cout     (sl_co[g]),
            .c_msb_in (sl_cm[g])
        );
    end

    // Merge each resolved slice into the forwarded lower sum bits
    always_comb begin
        nxt_s = '0;
        for (int i = 0; i < Nstages; i++) begin
            nxt_s[i]            = src_s[i];
            nxt_s[i][i*S +: S]  = sl_s[i];
        end
    end

    // Final stage: overflow judgement and optional saturation mux
    always_comb begin
        fin_m   = src_m[L];
        fin_sum = nxt_s[L];
        if (fin_m[MODE_SIGND]) begin
            fin_ovf = sl_cm[L] ^ sl_co[L];
        end else if (fin_m[MODE_SUB]) begin
            fin_ovf = ~sl_co[L];
        end else begin
            fin_ovf = sl_co[L];
        end
`ifdef SAT_EN
        if (fin_ovf) begin
            if (fin_m[MODE_SIGND]) begin
                fin_sum = src_a[L][Nbits-1] ? SMIN : SMAX;
            end else begin
                fin_sum = fin_m[MODE_SUB] ? '0 : UMAX;
            end
        end
`endif
    end

    // Stage registers advance only where the ready chain allows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            m_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < Nstages; i++) begin
                if (rdy[i]) begin
                    v_q[i] <= src_v[i];
                    if (src_v[i]) begin
                        a_q[i] <= src_a[i];
                        b_q[i] <= src_b[i];
                        m_q[i] <= src_m[i];
                        c_q[i] <= sl_co[i];
                        s_q[i] <= (i == L) ? fin_sum
                                           : nxt_s[i];
                    end
                end
            end
            if (rdy[L] && src_v[L]) begin
                ovf_q <= fin_ovf;
            end
        end
    end

    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;

    logic unused_bits;
    assign unused_bits = ^{a_q[L], b_q[L], m_q[L], sl_cm};

endmodule
